bus_arbiter_2m: RTL and testbench

//  Two-master / one-slave arbiter for the CPU's valid/ready memory bus. M0 is the CPU_core bus port, M1 a

---
 rtl/bus_arbiter_2m_if.sv | 60 ++++++
 rtl/bus_arbiter_2m.sv | 160 ++++++++++++++++
 tb/tb_bus_arbiter_2m.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_2m_if.sv
// Bus bundle for the two-master / one-slave arbiter.
// "master" is the arbiter's own view (it drives the slave-side bus and the
// per-master return paths); "slave" is the environment: both requesters plus
// the memory behind BUS_*.
interface bus_arbiter_2m_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // requester 0 (CPU core port)
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_mode;
    logic          m0_valid;
    logic          m0_rready;
    logic          m0_wready;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m0_err;
    // requester 1 (debug loader / DMA)
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_mode;
    logic          m1_valid;
    logic          m1_rready;
    logic          m1_wready;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          m1_err;
    // shared slave bus
    logic [AW-1:0] BUS_addr;
    logic [DW-1:0] BUS_wdata;
    logic          BUS_mode;
    logic          BUS_valid;
    logic          BUS_rready;
    logic          BUS_wready;
    logic          BUS_rvalid;
    logic [DW-1:0] BUS_rdata;
    // one-hot grant {M1,M0}
    logic [1:0]    gnt;

    modport master (
        input  m0_addr, m0_wdata, m0_mode, m0_valid, m0_rready,
        input  m1_addr, m1_wdata, m1_mode, m1_valid, m1_rready,
        input  BUS_wready, BUS_rvalid, BUS_rdata,
        output m0_wready, m0_rvalid, m0_rdata, m0_err,
        output m1_wready, m1_rvalid, m1_rdata, m1_err,
        output BUS_addr, BUS_wdata, BUS_mode, BUS_valid, BUS_rready,
        output gnt
    );

    modport slave (
        output m0_addr, m0_wdata, m0_mode, m0_valid, m0_rready,
        output m1_addr, m1_wdata, m1_mode, m1_valid, m1_rready,
        output BUS_wready, BUS_rvalid, BUS_rdata,
        input  m0_wready, m0_rvalid, m0_rdata, m0_err,
        input  m1_wready, m1_rvalid, m1_rdata, m1_err,
        input  BUS_addr, BUS_wdata, BUS_mode, BUS_valid, BUS_rready,
        input  gnt
    );
endinterface

// File: rtl/bus_arbiter_2m.sv
// Two-master / one-slave arbiter for the valid/ready memory bus.
// Grants one whole transaction at a time (round-robin or fixed priority),
// passes the granted master straight through to the slave, and aborts a
// transaction the slave never finishes after TIMEOUT busy cycles.
module bus_arbiter_2m #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_2m_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    // Counter wide enough to hold TIMEOUT; it never needs to go past it.
    localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_last_m1;       // 1: M1 was served last, so M0 wins the next tie
    logic          w_last_m1_next;
    logic [CW-1:0] r_wdog;          // non-completing busy cycles of the current grant
    logic [CW-1:0] w_wdog_next;
    logic          r_err0;
    logic          r_err1;
    logic          w_err0_next;
    logic          w_err1_next;

    logic          w_busy;
    logic          w_sel_m1;
    logic          w_req_valid;
    logic          w_complete;
    logic          w_timeout;
    logic          w_tie_pick_m1;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_sel_m1 = (r_state == ST_BUSY1);

    // Slave-side bus: granted master's request, forced to zero when idle.
    always_comb begin
        bus.BUS_addr   = '0;
        bus.BUS_wdata  = '0;
        bus.BUS_mode   = 1'b0;
        bus.BUS_valid  = 1'b0;
        bus.BUS_rready = 1'b0;
        w_req_valid    = 1'b0;
        if (r_state == ST_BUSY0) begin
            bus.BUS_addr   = bus.m0_addr;
            bus.BUS_wdata  = bus.m0_wdata;
            bus.BUS_mode   = bus.m0_mode;
            bus.BUS_valid  = bus.m0_valid;
            bus.BUS_rready = bus.m0_rready;
            w_req_valid    = bus.m0_valid;
        end else if (r_state == ST_BUSY1) begin
            bus.BUS_addr   = bus.m1_addr;
            bus.BUS_wdata  = bus.m1_wdata;
            bus.BUS_mode   = bus.m1_mode;
            bus.BUS_valid  = bus.m1_valid;
            bus.BUS_rready = bus.m1_rready;
            w_req_valid    = bus.m1_valid;
        end
    end

    // Return path: only the granted master sees the slave's responses.
    always_comb begin
        bus.m0_wready = 1'b0;
        bus.m0_rvalid = 1'b0;
        bus.m0_rdata  = '0;
        bus.m1_wready = 1'b0;
        bus.m1_rvalid = 1'b0;
        bus.m1_rdata  = '0;
        if (r_state == ST_BUSY0) begin
            bus.m0_wready = bus.BUS_wready;
            bus.m0_rvalid = bus.BUS_rvalid;
            bus.m0_rdata  = bus.BUS_rdata;
        end else if (r_state == ST_BUSY1) begin
            bus.m1_wready = bus.BUS_wready;
            bus.m1_rvalid = bus.BUS_rvalid;
            bus.m1_rdata  = bus.BUS_rdata;
        end
    end

    assign bus.gnt    = {r_state == ST_BUSY1, r_state == ST_BUSY0};
    assign bus.m0_err = r_err0;
    assign bus.m1_err = r_err1;

    // A write completes on the accepted handshake, a read on the data beat.
    assign w_complete = w_busy &
                        ((bus.BUS_valid & bus.BUS_mode & bus.BUS_wready) |
                         (bus.BUS_rvalid & bus.BUS_rready));

    // Abort on the TIMEOUT-th non-completing cycle; a completion in that same
    // cycle still wins.
    assign w_timeout = (TIMEOUT != 0) && w_busy && w_req_valid && !w_complete &&
                       (r_wdog == WD_LAST);

    // On a tie, round-robin hands the bus to whoever was not served last.
    assign w_tie_pick_m1 = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_m1;

    // Next-state, rr pointer, watchdog and abort pulse.
    always_comb begin
        w_state_next   = r_state;
        w_last_m1_next = r_last_m1;
        w_wdog_next    = r_wdog;
        w_err0_next    = 1'b0;
        w_err1_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wdog_next = '0;
                if (bus.m0_valid && bus.m1_valid) begin
                    w_state_next = w_tie_pick_m1 ? ST_BUSY1 : ST_BUSY0;
                end else if (bus.m0_valid) begin
                    w_state_next = ST_BUSY0;
                end else if (bus.m1_valid) begin
                    w_state_next = ST_BUSY1;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (w_complete || !w_req_valid || w_timeout) begin
                    w_state_next   = ST_IDLE;
                    w_last_m1_next = w_sel_m1;
                    w_err0_next    = w_timeout & ~w_sel_m1;
                    w_err1_next    = w_timeout & w_sel_m1;
                end else if (r_wdog != WD_MAX) begin
                    w_wdog_next = r_wdog + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last_m1 <= 1'b1;
            r_wdog    <= '0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_last_m1 <= w_last_m1_next;
            r_wdog    <= w_wdog_next;
            r_err0    <= w_err0_next;
            r_err1    <= w_err1_next;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Bench for bus_arbiter_2m: a round-robin and a fixed-priority instance share
// one stimulus; a transaction-level model predicts every output each cycle.
module tb_bus_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // stimulus shared by both instances
    logic [AW-1:0] m_addr   [2] = '{default: '0};
    logic [DW-1:0] m_wdata  [2] = '{default: '0};
    logic          m_mode   [2] = '{default: 1'b0};
    logic          m_valid  [2] = '{default: 1'b0};
    logic          m_rready [2] = '{default: 1'b0};
    logic          s_wready = 1'b0;
    logic          s_rvalid = 1'b0;
    logic [DW-1:0] s_rdata  = '0;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    bus_arbiter_2m_if #(.AW(AW), .DW(DW)) bus_rr ();
    bus_arbiter_2m_if #(.AW(AW), .DW(DW)) bus_fp ();

    bus_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst), .bus(bus_rr)
    );
    bus_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .bus(bus_fp)
    );

    assign bus_rr.m0_addr    = m_addr[0];
    assign bus_rr.m0_wdata   = m_wdata[0];
    assign bus_rr.m0_mode    = m_mode[0];
    assign bus_rr.m0_valid   = m_valid[0];
    assign bus_rr.m0_rready  = m_rready[0];
    assign bus_rr.m1_addr    = m_addr[1];
    assign bus_rr.m1_wdata   = m_wdata[1];
    assign bus_rr.m1_mode    = m_mode[1];
    assign bus_rr.m1_valid   = m_valid[1];
    assign bus_rr.m1_rready  = m_rready[1];
    assign bus_rr.BUS_wready = s_wready;
    assign bus_rr.BUS_rvalid = s_rvalid;
    assign bus_rr.BUS_rdata  = s_rdata;

    assign bus_fp.m0_addr    = m_addr[0];
    assign bus_fp.m0_wdata   = m_wdata[0];
    assign bus_fp.m0_mode    = m_mode[0];
    assign bus_fp.m0_valid   = m_valid[0];
    assign bus_fp.m0_rready  = m_rready[0];
    assign bus_fp.m1_addr    = m_addr[1];
    assign bus_fp.m1_wdata   = m_wdata[1];
    assign bus_fp.m1_mode    = m_mode[1];
    assign bus_fp.m1_valid   = m_valid[1];
    assign bus_fp.m1_rready  = m_rready[1];
    assign bus_fp.BUS_wready = s_wready;
    assign bus_fp.BUS_rvalid = s_rvalid;
    assign bus_fp.BUS_rdata  = s_rdata;

    // ---------------- reference model (index 0: round-robin, 1: fixed) ----
    // owner: -1 nobody, else the master holding the bus this cycle.
    int         owner    [2] = '{-1, -1};
    int         busy_cyc [2] = '{0, 0};   // non-completing cycles so far
    int         last_srv [2] = '{1, 1};   // master served last (1 => M0 preferred)
    logic [1:0] err_exp  [2] = '{2'b00, 2'b00};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT will sample.
    task automatic model_step(input int k);
        int         o;
        int         nxt;
        int         nb;
        int         nl;
        logic [1:0] ne;
        logic       done;
        o   = owner[k];
        nxt = o;
        nb  = busy_cyc[k];
        nl  = last_srv[k];
        ne  = 2'b00;
        if (rst) begin
            nxt = -1;
            nb  = 0;
            nl  = 1;
        end else if (o < 0) begin
            nb = 0;
            if (m_valid[0] && m_valid[1])
                nxt = (k == 1) ? 0 : 1 - last_srv[k];
            else if (m_valid[0])
                nxt = 0;
            else if (m_valid[1])
                nxt = 1;
        end else begin
            done = (m_valid[o] && m_mode[o] && s_wready) || (s_rvalid && m_rready[o]);
            if (done || !m_valid[o]) begin
                nxt = -1;
                nl  = o;
            end else begin
                nb = nb + 1;
                if (TO != 0 && nb == TO) begin
                    nxt   = -1;
                    nl    = o;
                    ne[o] = 1'b1;
                end
            end
        end
        owner[k]    <= nxt;
        busy_cyc[k] <= nb;
        last_srv[k] <= nl;
        err_exp[k]  <= ne;
    endtask

    task automatic check_dut(
        input int k, input logic [1:0] gnt,
        input logic [AW-1:0] baddr, input logic [DW-1:0] bwdata,
        input logic bmode, input logic bvalid, input logic brready,
        input logic r0w, input logic r0v, input logic [DW-1:0] r0d,
        input logic r1w, input logic r1v, input logic [DW-1:0] r1d,
        input logic [1:0] errs);
        int           o;
        logic [127:0] exp_bus;
        logic [127:0] exp_r0;
        logic [127:0] exp_r1;
        o       = owner[k];
        exp_bus = '0;
        exp_r0  = '0;
        exp_r1  = '0;
        if (o >= 0)
            exp_bus = {m_addr[o], m_wdata[o], m_mode[o], m_valid[o], m_rready[o]};
        if (o == 0) exp_r0 = {s_wready, s_rvalid, s_rdata};
        if (o == 1) exp_r1 = {s_wready, s_rvalid, s_rdata};
        chk($sformatf("gnt%0d", k), gnt, (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00);
        chk($sformatf("bus%0d", k), {baddr, bwdata, bmode, bvalid, brready}, exp_bus);
        chk($sformatf("ret_m0_%0d", k), {r0w, r0v, r0d}, exp_r0);
        chk($sformatf("ret_m1_%0d", k), {r1w, r1v, r1d}, exp_r1);
        chk($sformatf("err%0d", k), errs, err_exp[k]);
    endtask

    // Mid-cycle: compare outputs, then advance the model for the next edge.
    always @(negedge clk) begin
        check_dut(0, bus_rr.gnt, bus_rr.BUS_addr, bus_rr.BUS_wdata, bus_rr.BUS_mode,
                  bus_rr.BUS_valid, bus_rr.BUS_rready,
                  bus_rr.m0_wready, bus_rr.m0_rvalid, bus_rr.m0_rdata,
                  bus_rr.m1_wready, bus_rr.m1_rvalid, bus_rr.m1_rdata,
                  {bus_rr.m1_err, bus_rr.m0_err});
        check_dut(1, bus_fp.gnt, bus_fp.BUS_addr, bus_fp.BUS_wdata, bus_fp.BUS_mode,
                  bus_fp.BUS_valid, bus_fp.BUS_rready,
                  bus_fp.m0_wready, bus_fp.m0_rvalid, bus_fp.m0_rdata,
                  bus_fp.m1_wready, bus_fp.m1_rvalid, bus_fp.m1_rdata,
                  {bus_fp.m1_err, bus_fp.m0_err});
        model_step(0);
        model_step(1);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_valid[i]  = 1'b0;
            m_mode[i]   = 1'b0;
            m_rready[i] = 1'b0;
            m_addr[i]   = '0;
            m_wdata[i]  = '0;
        end
        s_wready = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic start_read(input int i, input logic [AW-1:0] a);
        m_valid[i]  = 1'b1;
        m_mode[i]   = 1'b0;
        m_addr[i]   = a;
        m_rready[i] = 1'b1;
    endtask

    logic silent;

    initial begin
        do_reset();

        // single read from M0, data two cycles into the grant
        start_read(0, 32'h10);
        cyc();
        chk("t1_gnt", bus_rr.gnt, 2'b01);
        cyc();
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEADBEEF;
        #1;
        chk("t1_m0_rdata", bus_rr.m0_rdata, 32'hDEADBEEF);
        chk("t1_m1_rdata", bus_rr.m1_rdata, 32'h0);
        cyc();
        chk("t1_gnt_done", bus_rr.gnt, 2'b00);
        m_valid[0] = 1'b0;
        s_rvalid   = 1'b0;
        cyc();

        // simultaneous requests after reset, rr alternates, fixed keeps M0
        do_reset();
        start_read(0, 32'h100);
        start_read(1, 32'h200);
        s_rvalid = 1'b1;
        cyc();
        chk("t2_first_rr", bus_rr.gnt, 2'b01);
        chk("t2_first_fp", bus_fp.gnt, 2'b01);
        cyc();
        chk("t2_idle_gap", bus_rr.gnt, 2'b00);
        cyc();
        chk("t2_second_rr", bus_rr.gnt, 2'b10);
        chk("t2_second_fp", bus_fp.gnt, 2'b01);
        cyc();
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        cyc();
        start_read(0, 32'h104);
        start_read(1, 32'h204);
        cyc();
        chk("t2_repeat_rr", bus_rr.gnt, 2'b01);
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        s_rvalid   = 1'b0;
        cyc();
        cyc();

        // M1 write accepted on its third busy cycle
        do_reset();
        m_valid[1] = 1'b1;
        m_mode[1]  = 1'b1;
        m_addr[1]  = 32'h20;
        m_wdata[1] = 32'h55;
        cyc();
        chk("t3_gnt", bus_rr.gnt, 2'b10);
        chk("t3_addr", bus_rr.BUS_addr, 32'h20);
        cyc();
        cyc();
        s_wready = 1'b1;
        #1;
        chk("t3_m1_wready", bus_rr.m1_wready, 1'b1);
        chk("t3_m0_wready", bus_rr.m0_wready, 1'b0);
        cyc();
        chk("t3_gnt_done", bus_rr.gnt, 2'b00);
        s_wready   = 1'b0;
        m_valid[1] = 1'b0;
        cyc();

        // silent slave: watchdog abort, then the pending M1 gets its turn
        do_reset();
        start_read(0, 32'h30);
        start_read(1, 32'h40);
        cyc();
        chk("t4_gnt", bus_rr.gnt, 2'b01);
        cyc();
        cyc();
        cyc();
        chk("t4_no_err_yet", bus_rr.m0_err, 1'b0);
        cyc();
        chk("t4_err", bus_rr.m0_err, 1'b1);
        chk("t4_bus_valid", bus_rr.BUS_valid, 1'b0);
        chk("t4_gnt_idle", bus_rr.gnt, 2'b00);
        cyc();
        chk("t4_err_gone", bus_rr.m0_err, 1'b0);
        chk("t4_gnt_m1", bus_rr.gnt, 2'b10);
        chk("t4_fp_gnt_m0", bus_fp.gnt, 2'b01);
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        cyc();
        cyc();

        // completion exactly on the last allowed cycle beats the watchdog
        do_reset();
        start_read(0, 32'h50);
        cyc();
        cyc();
        cyc();
        cyc();
        s_rvalid = 1'b1;
        cyc();
        chk("t4b_no_err", bus_rr.m0_err, 1'b0);
        chk("t4b_gnt", bus_rr.gnt, 2'b00);
        s_rvalid   = 1'b0;
        m_valid[0] = 1'b0;
        cyc();

        // reset while busy, requester still asking afterwards
        do_reset();
        start_read(0, 32'h60);
        cyc();
        rst = 1'b1;
        cyc();
        chk("t5_gnt", bus_rr.gnt, 2'b00);
        chk("t5_bus_valid", bus_rr.BUS_valid, 1'b0);
        chk("t5_err", bus_rr.m0_err, 1'b0);
        rst = 1'b0;
        cyc();
        chk("t5_regrant", bus_rr.gnt, 2'b01);
        m_valid[0] = 1'b0;
        cyc();
        cyc();

        // fixed priority: M1 never granted while M0 keeps requesting
        do_reset();
        start_read(0, 32'h70);
        start_read(1, 32'h80);
        s_rvalid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            cyc();
            chk("t6_fp_no_m1", bus_fp.gnt[1], 1'b0);
        end
        clear_inputs();
        cyc();

        // randomized traffic, occasional silent slave and resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_valid[i]) begin
                    if ($urandom_range(2) == 0) begin
                        m_valid[i] = 1'b1;
                        m_addr[i]  = $urandom;
                        m_wdata[i] = $urandom;
                        m_mode[i]  = 1'($urandom_range(1));
                    end
                end else if ($urandom_range(24) == 0) begin
                    m_valid[i] = 1'b0;
                end
                m_rready[i] = ($urandom_range(3) != 0);
            end
            silent   = ((n % 300) >= 250);
            s_wready = !silent && ($urandom_range(2) == 0);
            s_rvalid = !silent && ($urandom_range(2) == 0);
            s_rdata  = $urandom;
            rst      = ($urandom_range(199) == 0);
            cyc();
        end
        rst = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
